// File: rtl/instr_fetch_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instr_fetch_ctrl_pkg: state encodings and opcodes shared by the   |
// | controller and the decoder.                                       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package instr_fetch_ctrl_pkg;

    // STATE_FIELDS must match the decoder's capture constant.
    typedef enum logic [2:0] {
        STATE_FETCH  = 3'd0,
        STATE_FIELDS = 3'd1,
        STATE_READ   = 3'd2,
        STATE_EXEC   = 3'd3,
        STATE_MEM    = 3'd4,
        STATE_WB     = 3'd5,
        STATE_HALT   = 3'd7
    } state_e;

    localparam logic [5:0] HALT_OPCODE = 6'h3F;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_ctrl_pc_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_unit: program counter with reset load, hold, increment and     |
// | branch load.                                                      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pc_unit #(
    parameter int                     PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                upd_en_i,
    input  logic                sel_branch_i,
    input  logic [PC_WIDTH-1:0] target_i,
    output logic [PC_WIDTH-1:0] pc_o
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (upd_en_i) begin
            pc_d = sel_branch_i ? target_i : pc_q + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instr_fetch_ctrl: multi-cycle controller FSM, instruction fetch,  |
// | instruction latch and retire counter.                             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int                     PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_ack,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [2:0]          state,
    output logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic [15:0]         retired
);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [15:0] retired_q, retired_d;
    logic        pc_upd;
    logic        pc_sel_branch;

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        retired_d     = retired_q;
        pc_upd        = 1'b0;
        pc_sel_branch = 1'b0;
        case (state_q)
            STATE_FETCH: begin
                if (!stall && imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = STATE_FIELDS;
                end
            end
            STATE_FIELDS: begin
                if (!stall) begin
                    state_d = (instr_q[31:26] == HALT_OPCODE) ? STATE_HALT : STATE_READ;
                end
            end
            STATE_READ: begin
                if (!stall) state_d = STATE_EXEC;
            end
            STATE_EXEC: begin
                // Branch inputs are only honoured on the unstalled cycle.
                if (!stall) begin
                    pc_upd        = 1'b1;
                    pc_sel_branch = branch_taken;
                    state_d       = STATE_MEM;
                end
            end
            STATE_MEM: begin
                if (!stall) state_d = STATE_WB;
            end
            STATE_WB: begin
                if (!stall) begin
                    retired_d = retired_q + 16'd1;
                    state_d   = STATE_FETCH;
                end
            end
            STATE_HALT: begin
                state_d = STATE_HALT;
            end
            default: begin
                state_d = STATE_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STATE_FETCH;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    pc_unit #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk          (clk),
        .rst          (rst),
        .upd_en_i     (pc_upd),
        .sel_branch_i (pc_sel_branch),
        .target_i     (branch_target),
        .pc_o         (pc)
    );

    assign imem_req    = (state_q == STATE_FETCH) && !stall && !rst;
    assign imem_addr   = pc;
    assign state       = state_q;
    assign instruction = instr_q;
    assign retired     = retired_q;
    assign halted      = (state_q == STATE_HALT);

endmodule
`default_nettype wire

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Multi-cycle processor controller and fetch stage. It sequences the 3-bit `state` that drives every stage, including `instr_sep`, which captures fields when `state` is FIELDS. It owns the PC, fetches 32-bit instruction words from instruction memory over a request/acknowledge handshake, and holds each instruction stable for the decoder. It applies branch redirects, stalls, halts and counts retired instructions.

## Interface
Parameters:
- `PC_WIDTH`, default 8: word-address width of the PC and instruction memory.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `stall` input 1: freezes the controller (see Operation).
- `imem_req` output 1: fetch request.
- `imem_addr` output PC_WIDTH: fetch word address. Always equals `pc`.
- `imem_rdata` input 32: instruction word. Valid only while `imem_ack` is high.
- `imem_ack` input 1: memory returns data this cycle.
- `branch_taken` input 1: redirect request, sampled only in EXEC.
- `branch_target` input PC_WIDTH: redirect word address.
- `state` output 3: current controller state.
- `instruction` output 32: last fetched instruction word.
- `pc` output PC_WIDTH: current PC.
- `halted` output 1: high while in HALT.
- `retired` output 16: count of completed instructions.

## Operation
- States and encodings:
  - FETCH = 0
  - FIELDS = 1
  - READ = 2
  - EXEC = 3
  - MEM = 4
  - WB = 5
  - HALT = 7
  - Encoding 6 is unused; if ever reached, go to FETCH next cycle.
- Reset values: `state` = FETCH, `pc` = RESET_PC, `instruction` = 0, `retired` = 0, `halted` = 0.
- `imem_req` = (`state` == FETCH) && !`stall` && !`rst`. It is combinational from registered state.
- FETCH: hold `imem_req` until a cycle where `imem_req` && `imem_ack`. In that cycle, latch `imem_rdata` into `instruction` and go to FIELDS. An ack while `imem_req` is low is ignored.
- FIELDS: if `instruction[31:26]` == 6'h3F (HALT opcode), go to HALT; otherwise go to READ.
- READ: go to EXEC.
- EXEC: set `pc` to `branch_target` if `branch_taken`, else `pc` + 1, then go to MEM. The increment wraps modulo 2^PC_WIDTH.
- MEM: go to WB.
- WB: increment `retired` (wraps at 16 bits) and go to FETCH.
- HALT: absorbing state. Only `rst` leaves it. `pc`, `instruction` and `retired` are frozen.
- `stall` high: state, `pc`, `instruction` and `retired` all hold. In EXEC, a stalled cycle performs no PC update; the update happens on the first unstalled EXEC cycle, using the `branch_*` values sampled then. `stall` has no effect in HALT.
- `instruction` changes only on an accepted fetch. It is therefore stable throughout FIELDS, so the decoder captures a consistent word.
- `rst` overrides everything, including a same-cycle ack, branch or stall. Reset mid-fetch drops the returning data.

## Timing
- Ack in the same cycle as request is allowed. Minimum instruction period is 6 cycles: FETCH, FIELDS, READ, EXEC, MEM, WB.
- Each memory wait cycle adds one FETCH cycle. Each stalled cycle adds one cycle in the current state.
- `instruction` is valid from the cycle `state` first reads FIELDS. Decoder fields are valid from READ onward.
- The new `pc` is visible the cycle after EXEC, i.e. during MEM. `imem_addr` for the next fetch equals it.
- `retired` updates on the WB→FETCH edge. `halted` rises the cycle `state` becomes HALT.

## Structure
- Shared package/header holds:
  - STATE_FETCH … STATE_WB and STATE_HALT encodings. STATE_FIELDS = 1 must stay identical to the decoder's constant.
  - HALT_OPCODE = 6'h3F.
- One natural sub-module, `pc_unit`: the PC register with reset load, hold, increment and branch load, driven by update-enable and select from the FSM.
- The FSM, instruction latch and retire counter live in the top.

## Test plan
- Reset, then `imem_ack` tied high with words 0x00000000 at address 0 and 0x20010005 at address 1:
  - `state` sequence is 0,1,2,3,4,5,0,1,…
  - `imem_addr` is 0 then 1.
  - `retired` is 1 after the first WB.
- Ack delayed 3 cycles:
  - FETCH lasts 4 cycles.
  - `imem_req` stays high throughout.
  - `instruction` changes only in the ack cycle.
- `branch_taken` = 1 with `branch_target` = 8'h40 held through EXEC: the next `imem_addr` is 0x40. With `pc` = 8'hFF and no branch, the next `pc` is 0x00.
- `stall` asserted for 2 cycles in EXEC with `branch_taken` high only on the final unstalled cycle:
  - State stays EXEC for 3 cycles.
  - The PC is loaded from `branch_target`.
- Fetch 0xFC000000 (HALT opcode):
  - FIELDS → HALT.
  - `halted` = 1 and `imem_req` = 0 indefinitely.
  - `retired` is unchanged.
  - `rst` returns to FETCH with `pc` = RESET_PC.
- `rst` asserted in FETCH in the same cycle as `imem_ack` with data 0x12345678: `instruction` stays 0 and `state` stays FETCH.
